// File: rtl/exception_pkg.sv
// Shared types for the commit-stage exception unit: exception codes, FSM
// states, the default exception vector and the per-slot decode result.
package exception_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_CPU  = 5'h0b,
        EXC_OV   = 5'h0c,
        EXC_TR   = 5'h0d
    } exc_code_t;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    typedef struct packed {
        logic      hit;
        logic      is_eret;
        exc_code_t code;
        logic      bad_pc;
        logic      bad_mem;
    } slot_result_t;

endpackage

// File: rtl/exc_slot_decode.sv
// Priority encoder for the events of one commit slot.
// The trap input exists only when EXCEPTION_TRAP_EN is defined.
module exc_slot_decode
    import exception_pkg::*;
(
    input  logic         valid,
    input  logic         int_req,
    input  logic         iaddr_err,
    input  logic         daddr_err,
    input  logic         mem_wen,
    input  logic         ri,
    input  logic         cpu_unusable,
    input  logic         syscall,
    input  logic         break_,
    input  logic         overflow,
`ifdef EXCEPTION_TRAP_EN
    input  logic         trap,
`endif
    input  logic         eret,
    output slot_result_t result
);

    always_comb begin
        // NOTE: default the whole result first so no branch can infer a latch.
        result     = '0;
        result.hit = valid;
        if (valid) begin
            if (int_req)           result.code = EXC_INT;
            else if (iaddr_err) begin
                result.code   = EXC_ADEL;
                result.bad_pc = 1'b1;
            end
            else if (syscall)      result.code = EXC_SYS;
            else if (break_)       result.code = EXC_BP;
            else if (ri)           result.code = EXC_RI;
            else if (cpu_unusable) result.code = EXC_CPU;
            else if (overflow)     result.code = EXC_OV;
`ifdef EXCEPTION_TRAP_EN
            else if (trap)         result.code = EXC_TR;
`endif
            else if (eret)         result.is_eret = 1'b1;
            else if (daddr_err) begin
                result.code    = mem_wen ? EXC_ADES : EXC_ADEL;
                result.bad_mem = 1'b1;
            end
            else                   result.hit = 1'b0;
        end
    end

endmodule

// File: rtl/exception_beta.sv
// Commit-stage exception unit: picks the oldest excepting slot, reports it to
// CP0 and holds a fetch redirect until acknowledged. Option: EXCEPTION_TRAP_EN.
module exception_beta
    import exception_pkg::*;
#(
    parameter int          N_SLOTS    = 2,
    parameter int          N_INT      = 8,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    localparam int         SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [N_SLOTS-1:0] slot_valid,
    input  logic [N_SLOTS-1:0] iaddr_err,
    input  logic [N_SLOTS-1:0] daddr_err,
    input  logic [N_SLOTS-1:0] mem_wen,
    input  logic [N_SLOTS-1:0] ri,
    input  logic [N_SLOTS-1:0] cpu_unusable,
    input  logic [N_SLOTS-1:0] syscall,
    input  logic [N_SLOTS-1:0] break_,
    input  logic [N_SLOTS-1:0] overflow,
`ifdef EXCEPTION_TRAP_EN
    input  logic [N_SLOTS-1:0] trap,
`endif
    input  logic [N_SLOTS-1:0] eret,
    input  logic [N_SLOTS-1:0] is_branch,
    input  logic [31:0]        pc [N_SLOTS],
    input  logic [31:0]        mem_addr [N_SLOTS],
    input  logic [31:0]        epc_in,
    input  logic               allow_int,
    input  logic [N_INT-1:0]   int_flag,
    input  logic               redirect_ready,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               cp0_exp_en,
    output logic               cp0_exl_clean,
    output logic [4:0]         cp0_exp_code,
    output logic [31:0]        cp0_exp_epc,
    output logic               cp0_exp_bd,
    output logic [31:0]        cp0_bad_vaddr,
    output logic               cp0_bad_vaddr_wen,
    output logic [SLOT_W-1:0]  exp_slot
);

    state_t             state;
    logic               last_branch;
    logic               int_req;
    slot_result_t       res [N_SLOTS];
    logic [N_SLOTS-1:0] bd;

    logic               found;
    logic [SLOT_W-1:0]  sel;
    slot_result_t       sel_res;
    logic [31:0]        sel_pc;
    logic [31:0]        sel_addr;
    logic               sel_bd;
    logic               next_branch;

    assign int_req = allow_int && (int_flag != '0);

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        exc_slot_decode u_dec (
            .valid        (slot_valid[g]),
            .int_req      ((g == 0) ? int_req : 1'b0),
            .iaddr_err    (iaddr_err[g]),
            .daddr_err    (daddr_err[g]),
            .mem_wen      (mem_wen[g]),
            .ri           (ri[g]),
            .cpu_unusable (cpu_unusable[g]),
            .syscall      (syscall[g]),
            .break_       (break_[g]),
            .overflow     (overflow[g]),
`ifdef EXCEPTION_TRAP_EN
            .trap         (trap[g]),
`endif
            .eret         (eret[g]),
            .result       (res[g])
        );
    end

    // Slot 0's branch predecessor committed in an earlier cycle.
    always_comb begin
        bd    = '0;
        bd[0] = last_branch;
        for (int i = 1; i < N_SLOTS; i++) bd[i] = slot_valid[i-1] & is_branch[i-1];
    end

    always_comb begin
        found       = 1'b0;
        sel         = '0;
        sel_res     = '0;
        sel_pc      = '0;
        sel_addr    = '0;
        sel_bd      = 1'b0;
        next_branch = last_branch;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (slot_valid[i]) next_branch = is_branch[i];
            if (!found && res[i].hit) begin
                found    = 1'b1;
                sel      = SLOT_W'(i);
                sel_res  = res[i];
                sel_pc   = pc[i];
                sel_addr = mem_addr[i];
                sel_bd   = bd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last_branch       <= 1'b0;
            flush             <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= EXC_VECTOR;
            cp0_exp_en        <= 1'b0;
            cp0_exl_clean     <= 1'b0;
            cp0_exp_code      <= '0;
            cp0_exp_epc       <= '0;
            cp0_exp_bd        <= 1'b0;
            cp0_bad_vaddr     <= '0;
            cp0_bad_vaddr_wen <= 1'b0;
            exp_slot          <= '0;
        end else begin
            // NOTE: CP0 strobes default low every cycle so a capture yields a one-cycle pulse.
            cp0_exp_en        <= 1'b0;
            cp0_exl_clean     <= 1'b0;
            cp0_bad_vaddr_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stall) begin
                        if (found) begin
                            state             <= REDIRECT;
                            flush             <= 1'b1;
                            redirect_valid    <= 1'b1;
                            redirect_pc       <= sel_res.is_eret ? epc_in : EXC_VECTOR;
                            cp0_exp_en        <= !sel_res.is_eret;
                            cp0_exl_clean     <= sel_res.is_eret;
                            cp0_exp_code      <= sel_res.code;
                            cp0_exp_epc       <= sel_bd ? (sel_pc - 32'd4) : sel_pc;
                            cp0_exp_bd        <= sel_bd;
                            cp0_bad_vaddr     <= sel_res.bad_pc  ? sel_pc :
                                                 sel_res.bad_mem ? sel_addr : '0;
                            cp0_bad_vaddr_wen <= sel_res.bad_pc | sel_res.bad_mem;
                            exp_slot          <= sel;
                            last_branch       <= 1'b0;
                        end else begin
                            last_branch <= next_branch;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
